// File: rtl/stdp_weight_update.sv
// STDP plasticity controller for a single synapse.
// Keeps decaying pre/post spike traces, turns spike pairings into weight
// deltas, and drives an external 8-bit adder to update a saturating weight.
`timescale 1ns/1ps
module stdp_weight_update #(
  parameter logic [3:0] TRACE_MAX = 4'd15,
  parameter logic [7:0] W_RESET   = 8'd128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  input  logic       w_load,
  input  logic [7:0] w_init,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_sum,
  input  logic       add_cout,
  output logic [7:0] weight,
  output logic       w_upd,
  output logic       busy,
  output logic [3:0] drop_cnt
);

  typedef enum logic {IDLE, UPDATE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  preTrace_q, preTrace_d;
  logic [3:0]  postTrace_q, postTrace_d;
  logic [7:0]  weight_q, weight_d;
  logic        op_q, op_d;
  logic [3:0]  delta_q, delta_d;
  logic        pendValid_q, pendValid_d;
  logic        wUpd_q, wUpd_d;
  logic [3:0]  dropCnt_q, dropCnt_d;

  logic        ltpEv;
  logic        ltdEv;
  logic        evValid;
  logic [3:0]  evDelta;
  logic [7:0]  satResult;

  // Events are qualified on the trace values from before this edge's reload/decay.
  assign ltpEv   = learn_en & post_spike & ~pre_spike & (preTrace_q != 4'd0);
  assign ltdEv   = learn_en & pre_spike & ~post_spike & (postTrace_q != 4'd0);
  assign evValid = ltpEv | ltdEv;
  assign evDelta = ltdEv ? postTrace_q : preTrace_q;

  // Depression saturates at 0 on borrow (no carry out), potentiation at 255 on carry.
  assign satResult = op_q ? (add_cout ? add_sum : 8'd0)
                          : (add_cout ? 8'hFF : add_sum);

  assign weight   = weight_q;
  assign w_upd    = wUpd_q;
  assign busy     = (state_q == UPDATE);
  assign drop_cnt = dropCnt_q;

  // Traces reload on their own spike and otherwise decay toward zero, free of the FSM.
  always_comb begin
    preTrace_d  = preTrace_q;
    postTrace_d = postTrace_q;
    if (pre_spike)                preTrace_d  = TRACE_MAX;
    else if (preTrace_q != 4'd0)  preTrace_d  = preTrace_q - 4'd1;
    if (post_spike)               postTrace_d = TRACE_MAX;
    else if (postTrace_q != 4'd0) postTrace_d = postTrace_q - 4'd1;
  end

  // Adder operands are only presented during UPDATE; LTD uses ~delta + 1 to subtract.
  always_comb begin
    add_a   = 8'd0;
    add_b   = 8'd0;
    add_cin = 1'b0;
    if (state_q == UPDATE) begin
      add_a   = weight_q;
      add_b   = op_q ? ~{4'd0, delta_q} : {4'd0, delta_q};
      add_cin = op_q;
    end
  end

  // Next-state logic; a queued event loads straight into op/delta for the following
  // UPDATE and pendValid keeps the one-deep slot occupied until that UPDATE closes.
  always_comb begin
    state_d     = state_q;
    weight_d    = weight_q;
    op_d        = op_q;
    delta_d     = delta_q;
    pendValid_d = pendValid_q;
    wUpd_d      = 1'b0;
    dropCnt_d   = dropCnt_q;
    if (w_load) begin
      weight_d    = w_init;
      state_d     = IDLE;
      pendValid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pendValid_d = 1'b0;
          if (evValid) begin
            state_d = UPDATE;
            op_d    = ltdEv;
            delta_d = evDelta;
          end
        end
        UPDATE: begin
          weight_d = satResult;
          wUpd_d   = 1'b1;
          if (pendValid_q) begin
            pendValid_d = 1'b0;
            state_d     = IDLE;
            if (evValid && (dropCnt_q != 4'hF)) dropCnt_d = dropCnt_q + 4'd1;
          end else if (evValid) begin
            pendValid_d = 1'b1;
            state_d     = UPDATE;
            op_d        = ltdEv;
            delta_d     = evDelta;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers; reset abandons any in-flight update without writing the weight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      preTrace_q  <= 4'd0;
      postTrace_q <= 4'd0;
      weight_q    <= W_RESET;
      op_q        <= 1'b0;
      delta_q     <= 4'd0;
      pendValid_q <= 1'b0;
      wUpd_q      <= 1'b0;
      dropCnt_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      preTrace_q  <= preTrace_d;
      postTrace_q <= postTrace_d;
      weight_q    <= weight_d;
      op_q        <= op_d;
      delta_q     <= delta_d;
      pendValid_q <= pendValid_d;
      wUpd_q      <= wUpd_d;
      dropCnt_q   <= dropCnt_d;
    end
  end

endmodule

// File: tb/tb_stdp_weight_update.sv
// Scoreboard bench for stdp_weight_update with an ideal ripple adder model.
`timescale 1ns/1ps
module tb_stdp_weight_update;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pre_spike, post_spike, learn_en, w_load;
  logic [7:0] w_init;
  logic [7:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic [7:0] weight;
  logic       w_upd, busy;
  logic [3:0] drop_cnt;
  logic [8:0] adderFull;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
  } opExp_t;

  opExp_t     opQ[$];
  logic [7:0] wQ[$];
  opExp_t     expOp;
  logic [7:0] expW;
  int         checks = 0;
  int         errors = 0;
  int         wModel;

  stdp_weight_update #(.TRACE_MAX(4'd15), .W_RESET(8'd128)) dut (
    .clk(clk), .rst_n(rst_n),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .learn_en(learn_en), .w_load(w_load), .w_init(w_init),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .weight(weight), .w_upd(w_upd), .busy(busy), .drop_cnt(drop_cnt)
  );

  // External 8-bit adder: the environment the controller drives.
  assign adderFull = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  assign add_sum   = adderFull[7:0];
  assign add_cout  = adderFull[8];

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic pre, input logic post, input logic learn,
                               input logic load, input logic [7:0] init);
    pre_spike  = pre;
    post_spike = post;
    learn_en   = learn;
    w_load     = load;
    w_init     = init;
    @(posedge clk);
    #1;
    pre_spike  = 1'b0;
    post_spike = 1'b0;
    w_load     = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
  endtask

  task automatic pushOp(input logic [7:0] a, input logic [7:0] b, input logic cin);
    opQ.push_back('{a: a, b: b, cin: cin});
  endtask

  function automatic logic [7:0] satAdd(input int w, input int d);
    int r;
    r = w + d;
    if (r > 255) r = 255;
    if (r < 0) r = 0;
    return 8'(r);
  endfunction

  // Monitor: pops expected operands whenever busy, expected weight whenever w_upd.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy) begin
        if (opQ.size() == 0) checkOutput("unexpected_busy", 32'd1, 32'd0);
        else begin
          expOp = opQ.pop_front();
          checkOutput("add_a", 32'(add_a), 32'(expOp.a));
          checkOutput("add_b", 32'(add_b), 32'(expOp.b));
          checkOutput("add_cin", 32'(add_cin), 32'(expOp.cin));
        end
      end else begin
        checkOutput("idle_operands", 32'({add_a, add_b, add_cin}), 32'd0);
      end
      if (w_upd) begin
        if (wQ.size() == 0) checkOutput("unexpected_w_upd", 32'd1, 32'd0);
        else begin
          expW = wQ.pop_front();
          checkOutput("weight_upd", 32'(weight), 32'(expW));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    pre_spike = 1'b0; post_spike = 1'b0; learn_en = 1'b1; w_load = 1'b0; w_init = 8'd0;
    idleCycles(2);
    checkOutput("rst_weight", 32'(weight), 32'd128);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_w_upd", 32'(w_upd), 32'd0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    checkOutput("rst_operands", 32'({add_a, add_b, add_cin}), 32'd0);
    rst_n = 1'b1;

    // LTP: pre at edge 0, post at edge 3 with pre_trace 13.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    idleCycles(2);
    pushOp(8'd128, 8'd13, 1'b0); wQ.push_back(8'd141);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idleCycles(1);
    checkOutput("t1_weight", 32'(weight), 32'd141);
    idleCycles(16);

    // LTD: post at edge 0, pre at edge 2 with post_trace 14.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd100);
    checkOutput("t2_load", 32'(weight), 32'd100);
    checkOutput("t2_load_no_upd", 32'(w_upd), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idleCycles(1);
    pushOp(8'd100, 8'hF1, 1'b1); wQ.push_back(8'd86);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    idleCycles(2);
    checkOutput("t2_weight", 32'(weight), 32'd86);
    idleCycles(16);

    // Saturation at 255 and at 0.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd250);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    pushOp(8'd250, 8'd15, 1'b0); wQ.push_back(8'd255);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idleCycles(1);
    checkOutput("t3_sat_high", 32'(weight), 32'd255);
    idleCycles(16);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    pushOp(8'd5, 8'hF0, 1'b1); wQ.push_back(8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    idleCycles(1);
    checkOutput("t3_sat_low", 32'(weight), 32'd0);
    idleCycles(16);

    // Simultaneous spikes: no event, both traces reload to 15.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd60);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'd0);
    checkOutput("t4_both_no_busy", 32'(busy), 32'd0);
    checkOutput("t4_both_weight", 32'(weight), 32'd60);
    pushOp(8'd60, 8'd15, 1'b0); wQ.push_back(8'd75);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idleCycles(1);
    checkOutput("t4_reloaded_trace", 32'(weight), 32'd75);
    // learn_en low: valid pairing ignored and not counted.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    idleCycles(1);
    checkOutput("t4_learn_off_weight", 32'(weight), 32'd75);
    checkOutput("t4_learn_off_drops", 32'(drop_cnt), 32'd0);
    idleCycles(16);

    // Three consecutive events: two back-to-back updates, one drop.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd128);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    pushOp(8'd128, 8'd15, 1'b0); wQ.push_back(8'd143);
    pushOp(8'd143, 8'd14, 1'b0); wQ.push_back(8'd157);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    idleCycles(1);
    checkOutput("t5_drop_one", 32'(drop_cnt), 32'd1);
    checkOutput("t5_weight", 32'(weight), 32'd157);
    wModel = 157;
    for (int g = 0; g < 20; g++) begin
      pushOp(8'(wModel), 8'd15, 1'b0);
      wModel = int'(satAdd(wModel, 15));
      wQ.push_back(8'(wModel));
      pushOp(8'(wModel), 8'd14, 1'b0);
      wModel = int'(satAdd(wModel, 14));
      wQ.push_back(8'(wModel));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    end
    idleCycles(1);
    checkOutput("t5_drop_sat", 32'(drop_cnt), 32'd15);
    checkOutput("t5_weight_sat", 32'(weight), 32'd255);
    idleCycles(16);

    // w_load during a queued UPDATE discards it and clears the queue.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd40);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    pushOp(8'd40, 8'd15, 1'b0); wQ.push_back(8'd55);
    pushOp(8'd55, 8'd14, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'd77);
    checkOutput("t6_load_weight", 32'(weight), 32'd77);
    checkOutput("t6_load_no_upd", 32'(w_upd), 32'd0);
    checkOutput("t6_load_idle", 32'(busy), 32'd0);
    idleCycles(3);
    checkOutput("t6_load_kept", 32'(weight), 32'd77);
    idleCycles(16);

    // Reset mid-UPDATE: immediate return to reset values, traces cleared.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'd0);
    pushOp(8'd77, 8'd15, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_weight", 32'(weight), 32'd128);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_w_upd", 32'(w_upd), 32'd0);
    checkOutput("t6_rst_operands", 32'({add_a, add_b, add_cin}), 32'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'd0);
    checkOutput("t6_rst_trace_clear", 32'(busy), 32'd0);
    idleCycles(2);
    checkOutput("t6_rst_weight_kept", 32'(weight), 32'd128);

    checkOutput("opq_drained", 32'(opQ.size()), 32'd0);
    checkOutput("wq_drained", 32'(wQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
